// File: rtl/mdu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : mdu_multicycle
// Description : Iterative RISC-V M-extension multiply/divide unit for the
//               execute stage. It handles MUL, MULH, MULHSU, MULHU, DIV,
//               DIVU, REM and REMU. It uses one radix-2 step per clock:
//               shift-add for multiply and restoring division for divide.
//               Valid/ready handshakes on both sides let the pipeline
//               stall on the unit.
//
// Ports       : clock      - system clock, rising edge
//               reset      - synchronous active-high reset
//               in_valid   - request valid
//               in_ready   - unit can accept a request (IDLE only)
//               op         - funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                                    4 DIV 5 DIVU 6 REM 7 REMU
//               A, B       - rs1 / rs2 operands (N bits)
//               out_valid  - Y holds a valid result
//               out_ready  - consumer accepts the result
//               Y          - result (N bits)
//               busy       - unit is not IDLE
//
// Options     : MDU_DIV_CACHE_EN - when defined, the unit keeps the operands
//               and the quotient/remainder of the last computed division.
//               A matching follow-up division then completes in one cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_multicycle #(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic         busy
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [N-1:0]    r_hi;      // product high half / partial remainder
    logic [N-1:0]    r_lo;      // product low half + multiplier / quotient
    logic [N-1:0]    r_opb;     // multiplicand or divisor magnitude
    logic            r_neg_q;   // negate product or quotient in FIX
    logic            r_neg_r;   // negate remainder in FIX
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic [N-1:0]    r_y;

    // ------------------------------------------------------------------
    // Request decode (valid while in IDLE)
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [N-1:0]    w_mag_a;
    logic [N-1:0]    w_mag_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [N-1:0]    w_spec_y;

    assign w_accept   = in_valid && r_in_ready;
    assign w_is_div   = op[2];
    assign w_a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_neg_a    = w_a_signed && A[N-1];
    assign w_neg_b    = w_b_signed && B[N-1];
    assign w_mag_a    = w_neg_a ? ({N{1'b0}} - A) : A;
    assign w_mag_b    = w_neg_b ? ({N{1'b0}} - B) : B;
    assign w_b_zero   = (B == {N{1'b0}});
    // Signed division only: most negative / -1 overflows the quotient.
    assign w_ovf      = w_is_div && !op[0] &&
                        (A == {1'b1, {(N-1){1'b0}}}) && (B == {N{1'b1}});
    assign w_special  = w_is_div && (w_b_zero || w_ovf);
    // op[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
    assign w_spec_y   = w_b_zero ? (op[1] ? A : {N{1'b1}})
                                 : (op[1] ? {N{1'b0}} : A);

    // ------------------------------------------------------------------
    // Division result cache
    // ------------------------------------------------------------------
    logic            w_hit;
    logic [N-1:0]    w_hit_y;

`ifdef MDU_DIV_CACHE_EN
    logic            r_c_valid;
    logic [N-1:0]    r_c_a;
    logic [N-1:0]    r_c_b;
    logic            r_c_signed;
    logic [N-1:0]    r_c_quo;
    logic [N-1:0]    r_c_rem;

    assign w_hit   = r_c_valid && w_is_div && !w_special &&
                     (A == r_c_a) && (B == r_c_b) && (r_c_signed == !op[0]);
    assign w_hit_y = op[1] ? r_c_rem : r_c_quo;
`else
    assign w_hit   = 1'b0;
    assign w_hit_y = {N{1'b0}};
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [N:0]      w_sum;
    logic [N:0]      w_trial;
    logic [N:0]      w_diff;
    logic            w_ge;

    // Shift-add step: add the multiplicand when the multiplier LSB is set,
    // then shift the whole {carry, hi, lo} right by one.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(N+1){1'b0}});
    // Restoring step: the shifted partial remainder is below 2*divisor.
    // A borrow into bit N therefore means the trial subtraction failed.
    assign w_trial = {r_hi, r_lo[N-1]};
    assign w_diff  = w_trial - {1'b0, r_opb};
    assign w_ge    = !w_diff[N];

    // ------------------------------------------------------------------
    // FIX stage: sign correction and half/quotient/remainder select
    // ------------------------------------------------------------------
    logic [2*N-1:0]  w_prod;
    logic [2*N-1:0]  w_prod_fix;
    logic [N-1:0]    w_quo;
    logic [N-1:0]    w_rem;
    logic [N-1:0]    w_res;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? ({(2*N){1'b0}} - w_prod) : w_prod;
    assign w_quo      = r_neg_q ? ({N{1'b0}} - r_lo) : r_lo;
    assign w_rem      = r_neg_r ? ({N{1'b0}} - r_hi) : r_hi;

    always_comb begin
        w_res = {N{1'b0}};
        case (r_op)
            3'd0:                w_res = w_prod_fix[N-1:0];
            3'd1, 3'd2, 3'd3:    w_res = w_prod_fix[2*N-1:N];
            3'd4, 3'd5:          w_res = w_quo;
            default:             w_res = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_op        <= 3'd0;
            r_hi        <= {N{1'b0}};
            r_lo        <= {N{1'b0}};
            r_opb       <= {N{1'b0}};
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_y         <= {N{1'b0}};
`ifdef MDU_DIV_CACHE_EN
            r_c_valid   <= 1'b0;
            r_c_a       <= {N{1'b0}};
            r_c_b       <= {N{1'b0}};
            r_c_signed  <= 1'b0;
            r_c_quo     <= {N{1'b0}};
            r_c_rem     <= {N{1'b0}};
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op;
                        r_cnt      <= {CW{1'b0}};
                        r_neg_q    <= w_neg_a ^ w_neg_b;
                        r_neg_r    <= w_neg_a;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_hi       <= {N{1'b0}};
                        // Multiply keeps the multiplier in lo and adds A's
                        // magnitude. Divide shifts the dividend out of lo.
                        r_lo       <= w_is_div ? w_mag_a : w_mag_b;
                        r_opb      <= w_is_div ? w_mag_b : w_mag_a;
                        if (w_special) begin
                            r_y         <= w_spec_y;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_hit) begin
                            r_y         <= w_hit_y;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state     <= S_CALC;
                        end
`ifdef MDU_DIV_CACHE_EN
                        // Multiplies and special cases drop the cache.
                        // A new division claims the key now and becomes
                        // valid once FIX has produced its results.
                        if (!w_is_div || w_special) begin
                            r_c_valid <= 1'b0;
                        end else if (!w_hit) begin
                            r_c_valid  <= 1'b0;
                            r_c_a      <= A;
                            r_c_b      <= B;
                            r_c_signed <= !op[0];
                        end
`endif
                    end
                end

                S_CALC: begin
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_diff[N-1:0] : w_trial[N-1:0];
                        r_lo <= {r_lo[N-2:0], w_ge};
                    end else begin
                        r_hi <= w_sum[N:1];
                        r_lo <= {w_sum[0], r_lo[N-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N-1)) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    r_y         <= w_res;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
`ifdef MDU_DIV_CACHE_EN
                    if (r_op[2]) begin
                        r_c_valid <= 1'b1;
                        r_c_quo   <= w_quo;
                        r_c_rem   <= w_rem;
                    end
`endif
                end

                default: begin  // S_DONE
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign Y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_mdu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_multicycle
// Description : Directed self-checking bench for mdu_multicycle at N=32.
//               It checks results, accept-to-valid latency, backpressure,
//               reset abort and, when MDU_DIV_CACHE_EN is defined, the
//               division cache hit/miss latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_multicycle;

    localparam int N       = 32;
    localparam int LAT_CALC = N + 2;
`ifdef MDU_DIV_CACHE_EN
    localparam int LAT_HIT = 1;
`else
    localparam int LAT_HIT = N + 2;
`endif

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  Y;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    mdu_multicycle #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and check its result, its latency and the return
    // to IDLE after the result is consumed.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_y, input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        check_eq({tag, "_rdy"}, in_ready, 1'b1);
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        // Scramble the inputs so the result must come from registered copies.
        A = ~a; B = ~b; op = ~o;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check_eq({tag, "_y"}, Y, exp_y);
        check_eq({tag, "_lat"}, lat, exp_lat);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        int lat;
        logic seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; A = '0; B = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_y", Y, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Multiply
        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_CALC);
        run_op("mulhu",  3'd3, 32'd7,        32'hFFFFFFFD, 32'h00000006, LAT_CALC);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_CALC);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_CALC);
        run_op("mulh_neg", 3'd1, 32'hFFFFFFFF, 32'd5,      32'hFFFFFFFF, LAT_CALC);

        // Divide, signed and unsigned
        run_op("div_n7_2",  3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT_CALC);
        run_op("rem_n7_2",  3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_HIT);
        run_op("divu_100_7", 3'd5, 32'd100,     32'd7, 32'd14,       LAT_CALC);
        run_op("remu_100_7", 3'd7, 32'd100,     32'd7, 32'd2,        LAT_HIT);

        // Special cases (a special case also drops the cache)
        run_op("divu_b0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_after_spec", 3'd7, 32'd100, 32'd7,       32'd2,        LAT_CALC);
        run_op("rem_b0",    3'd6, 32'h1234,     32'd0,        32'h1234,     1);
        run_op("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

        // Cache hit, then invalidation by an intervening multiply
        run_op("div_100_7",  3'd4, 32'd100, 32'd7, 32'd14, LAT_CALC);
        run_op("rem_100_7",  3'd6, 32'd100, 32'd7, 32'd2,  LAT_HIT);
        run_op("divu_sgn",   3'd5, 32'd100, 32'd7, 32'd14, LAT_CALC);
        run_op("mul_3_5",    3'd0, 32'd3,   32'd5, 32'd15, LAT_CALC);
        run_op("rem_after_mul", 3'd6, 32'd100, 32'd7, 32'd2, LAT_CALC);

        // More sign combinations
        run_op("div_7_n2",  3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_CALC);
        run_op("rem_7_n2",  3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        LAT_HIT);
        run_op("div_n7_n2", 3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        LAT_CALC);

        // Backpressure, plus a request offered while busy is ignored
        op = 3'd3; A = 32'd7; B = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clock); #1;
        op = 3'd5; A = 32'd9; B = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 4;
        while (!out_valid && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check_eq("bp_lat", lat, LAT_CALC);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_hold", {Y, out_valid, in_ready, busy}, {32'h00000006, 3'b101});
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq("bp_release", {in_ready, out_valid, busy}, 3'b100);

        // Reset in the middle of CALC
        op = 3'd0; A = 32'd3; B = 32'd5; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check_eq("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("abort_state", {busy, in_ready, out_valid}, 3'b010);
        seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N + 5; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check_eq("abort_no_valid", seen, 1'b0);
        run_op("after_abort", 3'd0, 32'd3, 32'd5, 32'd15, LAT_CALC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
